req_capture4: RTL and testbench

- Request-capture stage directly upstream of the 4-to-2 priority encoder.
- Turns raw request lines into sticky pending bits that feed the encoder's 4-bit input.
- The consumer acknowledges the index the encoder produced, and this block clears that one pending bit.
- Also counts requests lost because they arrived while the same line was already pending.

---
 rtl/req_capture4.sv | 108 ++++++++++
 tb/tb_req_capture4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_capture4.sv
// req_capture4 -- request-capture stage feeding a 4-to-2 priority encoder.
//
// Raw request lines become sticky pending bits. The consumer acknowledges
// the encoded index and that single bit is cleared. Requests that arrive
// while their line is already pending are counted as drops in a saturating
// counter.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   req      raw request lines (N_REQ)
//   ack      acknowledge one request this cycle
//   ack_idx  index being acknowledged (IDX_W)
//   clr_cnt  synchronous clear of drop_cnt
//   pend     registered pending vector (encoder input)
//   any_pend OR of pend (encoder valid qualifier)
//   ack_err  one-cycle pulse: previous ack targeted a non-pending bit
//   drop_cnt saturating count of dropped requests (CNT_W)
//
// Optional macro REQ_SYNC_EN: adds a 2-flop synchronizer on req ahead of
// edge detection (req-to-pend latency 3 cycles instead of 1).

module req_capture4 #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned IDX_W     = 2,
  parameter int unsigned EDGE_MODE = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             clr_cnt,
  output logic [N_REQ-1:0] pend,
  output logic             any_pend,
  output logic             ack_err,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N_REQ-1:0] req_s;
  logic [N_REQ-1:0] req_d;
  logic [N_REQ-1:0] hit;
  logic [N_REQ-1:0] clear;
  logic [N_REQ-1:0] drop;
  logic             sel_pend;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W:0]   cnt_sum;

`ifdef REQ_SYNC_EN
  logic [N_REQ-1:0] sync1;
  logic [N_REQ-1:0] sync2;

  // Both stages preload the live req on reset so no false edge follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= req;
      sync2 <= req;
    end else begin
      sync1 <= req;
      sync2 <= sync1;
    end
  end

  assign req_s = sync2;
`else
  assign req_s = req;
`endif

  always_comb begin
    hit      = '0;
    clear    = '0;
    drop     = '0;
    drop_sum = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      hit[i]   = (EDGE_MODE != 0) ? (req_s[i] & ~req_d[i]) : req_s[i];
      clear[i] = ack && (ack_idx == IDX_W'(i));
      drop[i]  = hit[i] & pend[i] & ~clear[i];
      drop_sum = drop_sum + (CNT_W+1)'(drop[i]);
    end
    // An out-of-range ack_idx matches no bit, so it reads as non-pending.
    sel_pend = |(pend & clear);
    cnt_sum  = {1'b0, drop_cnt} + drop_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      ack_err  <= 1'b0;
      drop_cnt <= '0;
      req_d    <= req;
    end else begin
      // Set wins over clear: a new request is never lost to an ack.
      pend    <= hit | (pend & ~clear);
      ack_err <= ack & ~sel_pend;
      req_d   <= req_s;
      if (clr_cnt)
        drop_cnt <= '0;
      else if (cnt_sum[CNT_W])
        drop_cnt <= '1;
      else
        drop_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

  assign any_pend = |pend;

endmodule

// File: tb/tb_req_capture4.sv
module tb_req_capture4;

  localparam int EDGE_MODE = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic       ack = 1'b0;
  logic [1:0] ack_idx = '0;
  logic       clr_cnt = 1'b0;
  logic [3:0] pend;
  logic       any_pend;
  logic       ack_err;
  logic [7:0] drop_cnt;

  req_capture4 #(
    .N_REQ(4),
    .IDX_W(2),
    .EDGE_MODE(EDGE_MODE),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .ack(ack),
    .ack_idx(ack_idx),
    .clr_cnt(clr_cnt),
    .pend(pend),
    .any_pend(any_pend),
    .ack_err(ack_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pend;
    logic       err;
    int         cnt;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  // Reference model state: per-line pending flags, previous request view,
  // synchronizer history, drop count as a plain integer.
  bit m_pend[4];
  bit m_prev[4];
  bit m_s1[4];
  bit m_s2[4];
  bit m_err;
  int m_cnt;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic a, input int ai,
                            input logic cc, input logic rs);
    bit eff[4];
    bit nxt[4];
    int drops;
    exp_t e;
    if (rs) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0; m_prev[i] = r[i]; m_s1[i] = r[i]; m_s2[i] = r[i];
      end
      m_err = 0;
      m_cnt = 0;
    end else begin
      drops = 0;
      for (int i = 0; i < 4; i++) begin
`ifdef REQ_SYNC_EN
        eff[i] = m_s2[i];
`else
        eff[i] = r[i];
`endif
      end
      m_err = a && !m_pend[ai];
      for (int i = 0; i < 4; i++) begin
        bit h, c;
        h = (EDGE_MODE != 0) ? (eff[i] && !m_prev[i]) : eff[i];
        c = a && (ai == i);
        if (h && m_pend[i] && !c) drops++;
        nxt[i] = h || (m_pend[i] && !c);
      end
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = nxt[i];
        m_prev[i] = eff[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = r[i];
      end
      if (cc) m_cnt = 0;
      else m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
    end
    for (int i = 0; i < 4; i++) e.pend[i] = m_pend[i];
    e.err = m_err;
    e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  // Drive on the falling edge, let the rising edge act, return just after it.
  task automatic step(input logic [3:0] r, input logic a, input logic [1:0] ai,
                      input logic cc, input logic rs);
    @(negedge clk);
    req = r; ack = a; ack_idx = ai; clr_cnt = cc; rst = rs;
    model_edge(r, a, int'(ai), cc, rs);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [3:0] r);
    step(r, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Monitor: every rising edge with an outstanding expectation is checked.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("sb_pend", int'(pend), int'(e.pend));
      chk("sb_any_pend", int'(any_pend), int'(|e.pend));
      chk("sb_ack_err", int'(ack_err), int'(e.err));
      chk("sb_drop_cnt", int'(drop_cnt), e.cnt);
    end
  end

  initial begin
    // Line held high through reset creates no edge after release.
    step(4'b0101, 1'b0, 2'd0, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("reset_pend", int'(pend), 0);
    chk("reset_cnt", int'(drop_cnt), 0);
    chk("reset_err", int'(ack_err), 0);
    for (int k = 0; k < 5; k++) begin
      idle(4'b0101);
      chk("held_pend", int'(pend), 0);
      chk("held_any", int'(any_pend), 0);
    end

`ifndef REQ_SYNC_EN
    // Pulse then ack.
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(4'b0010);
    chk("pulse_pend", int'(pend), 4'b0010);
    idle(4'b0000);
    step(4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
    chk("ack_pend", int'(pend), 0);
    chk("ack_any", int'(any_pend), 0);
    chk("ack_err_ok", int'(ack_err), 0);

    // Set beats clear on the same bit; no drop counted.
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(4'b1000);
    idle(4'b0000);
    chk("p3_pend", int'(pend), 4'b1000);
    step(4'b1000, 1'b1, 2'd3, 1'b0, 1'b0);
    chk("setwin_pend", int'(pend), 4'b1000);
    chk("setwin_cnt", int'(drop_cnt), 0);

    // Bad ack pulses ack_err for one cycle, pend untouched.
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(4'b0100);
    idle(4'b0000);
    step(4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    chk("bad_ack_err", int'(ack_err), 1);
    chk("bad_ack_pend", int'(pend), 4'b0100);
    idle(4'b0000);
    chk("bad_ack_pulse", int'(ack_err), 0);
    chk("bad_ack_pend2", int'(pend), 4'b0100);

    // Saturation, then clear.
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(4'b1111);
    chk("all_pend", int'(pend), 4'b1111);
    for (int k = 0; k < 200; k++) idle((k % 2 == 0) ? 4'b0000 : 4'b1111);
    chk("sat_cnt", int'(drop_cnt), 255);
    idle(4'b0000);
    idle(4'b1111);
    chk("sat_hold", int'(drop_cnt), 255);
    step(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("clr_cnt", int'(drop_cnt), 0);
`else
    // Synchronized path: pend[0] rises exactly 3 edges after req[0] is sampled.
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    idle(4'b0001);
    chk("sync_lat1", int'(pend[0]), 0);
    idle(4'b0000);
    chk("sync_lat2", int'(pend[0]), 0);
    idle(4'b0000);
    chk("sync_lat3", int'(pend[0]), 1);
    step(4'b0011, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("sync_rst_pend", int'(pend), 0);
    chk("sync_rst_cnt", int'(drop_cnt), 0);
    chk("sync_rst_err", int'(ack_err), 0);
`endif

    // Randomized traffic against the model.
    step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      step(4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 63) == 0));
    end

    repeat (2) @(posedge clk);
    #3;
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
